// File: rtl/ioctl_loader_tx.sv
// ----------------------------------------------------------------------------
// ioctl_loader_tx
//   Transmitter end of the ROM/BIOS download bus. Streams a byte image taken
//   from a valid/ready byte source onto the ioctl_* bus, framed by
//   ioctl_download, one ioctl_wr strobe per byte, honouring ioctl_wait.
//
//   Timeline of one transfer:
//     start cycle + SETUP_CYCLES  -> per byte: FETCH (>=1), WRITE (1), GAP
//     (WR_GAP) -> TAIL (TAIL_CYCLES) -> done pulse, ioctl_download low.
//
// Optional feature: define IOCTL_TX_CHECKSUM_EN to add csum[15:0], the 16-bit
//   modular sum of every byte written, cleared on start.
//
// Ports:
//   clk_sys, reset            clock, asynchronous active-high reset
//   start, index, length      transfer request, image index, byte count
//   abort                     end the current transfer early
//   s_data, s_valid, s_ready  byte source handshake
//   ioctl_download/index/addr/dout/wr, ioctl_wait   download bus
//   busy, done, aborted       status; aborted is valid with done
//   csum                      (IOCTL_TX_CHECKSUM_EN only) byte sum
// ----------------------------------------------------------------------------
module ioctl_loader_tx #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned WR_GAP       = 3,
  parameter int unsigned TAIL_CYCLES  = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  index,
  input  logic [24:0] length,
  input  logic        abort,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        ioctl_download,
  output logic [7:0]  ioctl_index,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr,
  input  logic        ioctl_wait,
  output logic        busy,
  output logic        done,
`ifdef IOCTL_TX_CHECKSUM_EN
  output logic [15:0] csum,
`endif
  output logic        aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_WRITE, S_GAP, S_TAIL
  } state_e;

  // Terminal values of the shared cycle counter for each timed state.
  // SETUP counts 0..SETUP_CYCLES because the start cycle itself is not in it.
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES);
  localparam logic [7:0] GAP_LAST   = 8'(WR_GAP - 1);
  localparam logic [7:0] TAIL_LAST  = 8'(TAIL_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [24:0] len_q;
  logic        abort_q;
  logic [24:0] addr_d;
  logic        accept;

  // The byte counter and the address advance together, so ioctl_addr doubles
  // as the count of bytes already written.
  assign addr_d = ioctl_addr + 25'd1;

  // Combinational so that back-pressure and abort block acceptance in the
  // very cycle they are asserted.
  assign s_ready = (state_q == S_FETCH) && !ioctl_wait && !abort;
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      len_q          <= '0;
      abort_q        <= 1'b0;
      ioctl_download <= 1'b0;
      ioctl_index    <= '0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_wr       <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
`ifdef IOCTL_TX_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      ioctl_wr <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // start beats a simultaneous abort, which is simply not looked at.
          if (start) begin
            state_q        <= S_SETUP;
            cnt_q          <= '0;
            len_q          <= length;
            abort_q        <= 1'b0;
            ioctl_download <= 1'b1;
            ioctl_index    <= index;
            ioctl_addr     <= '0;
`ifdef IOCTL_TX_CHECKSUM_EN
            csum           <= '0;
`endif
          end
        end

        S_SETUP: begin
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= S_TAIL;
            cnt_q   <= '0;
          end else if (cnt_q == SETUP_LAST) begin
            state_q <= (len_q == '0) ? S_TAIL : S_FETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_FETCH: begin
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= S_TAIL;
            cnt_q   <= '0;
          end else if (accept) begin
            ioctl_dout <= s_data;
            ioctl_wr   <= 1'b1;
            state_q    <= S_WRITE;
          end
        end

        S_WRITE: begin
          // The strobe is already on the bus; this write always finishes.
          ioctl_addr <= addr_d;
`ifdef IOCTL_TX_CHECKSUM_EN
          csum       <= csum + {8'd0, ioctl_dout};
`endif
          cnt_q      <= '0;
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= S_TAIL;
          end else if (WR_GAP == 0) begin
            state_q <= (addr_d < len_q) ? S_FETCH : S_TAIL;
          end else begin
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= S_TAIL;
            cnt_q   <= '0;
          end else if (cnt_q == GAP_LAST) begin
            state_q <= (ioctl_addr < len_q) ? S_FETCH : S_TAIL;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_TAIL: begin
          if (cnt_q == TAIL_LAST) begin
            state_q        <= S_IDLE;
            ioctl_download <= 1'b0;
            done           <= 1'b1;
            aborted        <= abort_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_loader_tx.sv
// ----------------------------------------------------------------------------
// tb_ioctl_loader_tx
//   Directed and randomized transfers against ioctl_loader_tx. The expected
//   byte stream, addresses, window lengths and status come from the transfer
//   rules (bytes in order at 0..n-1, fixed setup/gap/tail lengths), not from
//   the design's state machine.
// ----------------------------------------------------------------------------
module tb_ioctl_loader_tx;

  localparam int SETUP = 4;
  localparam int GAP   = 3;
  localparam int TAIL  = 4;
  localparam int PITCH = 2 + GAP;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  index;
  logic [24:0] length;
  logic        abort;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic        busy;
  logic        done;
  logic        aborted;
`ifdef IOCTL_TX_CHECKSUM_EN
  logic [15:0] csum;
`endif

  always #5 clk_sys = ~clk_sys;

  ioctl_loader_tx #(
    .SETUP_CYCLES (SETUP),
    .WR_GAP       (GAP),
    .TAIL_CYCLES  (TAIL)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .start          (start),
    .index          (index),
    .length         (length),
    .abort          (abort),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .ioctl_wait     (ioctl_wait),
    .busy           (busy),
    .done           (done),
`ifdef IOCTL_TX_CHECKSUM_EN
    .csum           (csum),
`endif
    .aborted        (aborted)
  );

  int tests = 0;
  int fails = 0;

  // Results collected over one transfer.
  logic [7:0]  src[$];
  int          wr_addr[$];
  int          wr_data[$];
  int          wr_cyc[$];
  int          dl_cnt, done_seen, done_abt, done_addr, done_idx;
  int          ready_viol, hold_wr, fed;
  logic [15:0] done_csum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer: drives the source, back-pressure and abort cycle by cycle
  // and records what appears on the bus (sampled on the falling edge).
  task automatic run_xfer(input logic [7:0] idx, input int len, input int vpct,
                          input int wpct, input int abort_at, input int hold);
    int cyc       = 0;
    int hold_left = 0;
    bit held      = 0;
    bit abt_sent  = 0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    dl_cnt = 0; done_seen = 0; done_abt = 0; done_addr = 0; done_idx = 0;
    ready_viol = 0; hold_wr = 0; fed = 0; done_csum = '0;
    index  = idx;
    length = 25'(len);
    start  = 1'b1;
    @(posedge clk_sys); #1;
    start  = 1'b0;
    while (done_seen == 0 && cyc < 3000) begin
      s_valid = (fed < src.size()) && ($urandom_range(99) < vpct);
      s_data  = s_valid ? src[fed] : 8'($urandom);
      if (hold > 0 && !held && wr_addr.size() == 1) begin
        held      = 1;
        hold_left = hold;
      end
      ioctl_wait = (hold_left > 0) ? 1'b1 : ($urandom_range(99) < wpct);
      abort      = (abort_at >= 0) && !abt_sent && (wr_addr.size() == abort_at);
      if (abort) abt_sent = 1;
      @(negedge clk_sys);
      if (s_ready && (ioctl_wait || abort)) ready_viol++;
      if (s_valid && s_ready) fed++;
      if (ioctl_wr) begin
        wr_addr.push_back(int'(ioctl_addr));
        wr_data.push_back(int'(ioctl_dout));
        wr_cyc.push_back(cyc);
        if (hold_left > 0) hold_wr++;
      end
      if (hold_left > 0) hold_left--;
      if (ioctl_download) dl_cnt++;
      if (done) begin
        done_seen = 1;
        done_abt  = int'(aborted);
        done_addr = int'(ioctl_addr);
        done_idx  = int'(ioctl_index);
`ifdef IOCTL_TX_CHECKSUM_EN
        done_csum = csum;
`endif
      end
      @(posedge clk_sys); #1;
      cyc++;
    end
    s_valid = 1'b0; abort = 1'b0; ioctl_wait = 1'b0;
    check("done_within_budget", done_seen, 1);
  endtask

  // Expected: first n source bytes, in order, at addresses 0..n-1.
  task automatic verify_writes(input string tag, input int n, input bit exact_pitch);
    logic [15:0] sum = '0;
    check({tag, "_wr_count"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], i);
      check({tag, "_data"}, wr_data[i], int'(src[i]));
      if (i > 0) begin
        if (exact_pitch) check({tag, "_pitch"}, wr_cyc[i] - wr_cyc[i-1], PITCH);
        else             check({tag, "_pitch_min"}, int'(wr_cyc[i] - wr_cyc[i-1] >= PITCH), 1);
      end
    end
    for (int i = 0; i < n && i < src.size(); i++) sum = sum + 16'(src[i]);
    check({tag, "_final_addr"}, done_addr, n);
    check({tag, "_ready_rules"}, ready_viol, 0);
`ifdef IOCTL_TX_CHECKSUM_EN
    check({tag, "_csum"}, done_csum, sum);
`endif
  endtask

  task automatic wait_wr(input string tag);
    int found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk_sys);
      if (ioctl_wr) found = 1;
    end
    check({tag, "_wr_seen"}, found, 1);
    @(posedge clk_sys); #1;
  endtask

  initial begin
    int len, ab, n, seen_done;
    reset = 1'b1; start = 1'b0; index = '0; length = '0; abort = 1'b0;
    s_data = '0; s_valid = 1'b0; ioctl_wait = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk_sys);
    check("rst_download", ioctl_download, 0);
    check("rst_addr",     ioctl_addr, 0);
    check("rst_index",    ioctl_index, 0);
    check("rst_dout",     ioctl_dout, 0);
    check("rst_wr",       ioctl_wr, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     done, 0);
    check("rst_s_ready",  s_ready, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // Basic transfer.
    src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_xfer(8'h01, 4, 100, 0, -1, 0);
    verify_writes("basic", 4, 1'b1);
    check("basic_dl_len",  dl_cnt, 1 + SETUP + 4 * PITCH + TAIL);
    check("basic_aborted", done_abt, 0);
    check("basic_index",   done_idx, 8'h01);
    check("basic_done_1cyc", done, 0);
    check("basic_idle",    busy, 0);
    check("basic_addr_hold", ioctl_addr, 4);

    // Back-pressure after the first write.
    src.delete();
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    run_xfer(8'h02, 6, 100, 0, -1, 10);
    verify_writes("bp", 6, 1'b0);
    check("bp_no_wr_in_wait", hold_wr, 0);
    check("bp_aborted", done_abt, 0);

    // Zero length.
    src.delete();
    run_xfer(8'h03, 0, 100, 0, -1, 0);
    verify_writes("zero", 0, 1'b1);
    check("zero_dl_len",  dl_cnt, SETUP + TAIL + 1);
    check("zero_aborted", done_abt, 0);

    // Abort after two of eight bytes.
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(8'(8'h10 + i));
    run_xfer(8'h04, 8, 100, 0, 2, 0);
    verify_writes("abort", 2, 1'b1);
    check("abort_aborted", done_abt, 1);

`ifdef IOCTL_TX_CHECKSUM_EN
    // Checksum wraps modulo 2^16 of byte sum.
    src = '{8'hFF, 8'hFF, 8'h02};
    run_xfer(8'h05, 3, 100, 0, -1, 0);
    verify_writes("csum", 3, 1'b1);
    check("csum_value", done_csum, 16'h0200);
`endif

    // Randomized transfers with random stalls and occasional aborts.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 12);
      ab  = (t % 3 == 2) ? int'($urandom_range(0, len)) : -1;
      src.delete();
      for (int i = 0; i < len; i++) src.push_back(8'($urandom));
      run_xfer(8'($urandom), len, 70, 30, ab, 0);
      n = (ab >= 0 && ab < len) ? ab : len;
      verify_writes("rand", n, 1'b0);
      check("rand_aborted", done_abt, int'(ab >= 0));
    end

    // Start while busy is ignored; reset mid-transfer clears everything.
    index = 8'h22; length = 25'd8; s_data = 8'h5A; s_valid = 1'b1;
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    wait_wr("busy1");
    index = 8'h55; length = 25'd1; start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    check("busy_start_index", ioctl_index, 8'h22);
    check("busy_start_busy",  busy, 1);
    @(negedge clk_sys);
    while (!ioctl_wr && busy && ioctl_addr < 25'd3) @(negedge clk_sys);
    check("busy_start_addr",  ioctl_addr, 1);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_download", ioctl_download, 0);
    check("mid_rst_addr",     ioctl_addr, 0);
    check("mid_rst_index",    ioctl_index, 0);
    check("mid_rst_dout",     ioctl_dout, 0);
    check("mid_rst_busy",     busy, 0);
    check("mid_rst_s_ready",  s_ready, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0; s_valid = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (done || ioctl_download) seen_done = 1;
    end
    check("mid_rst_no_done", seen_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
